// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin Wishbone arbiter, N masters onto one bus.
// Optional forced-termination watchdog: WB_ARBITER_TIMEOUT_EN.
module wb_arbiter #(
   parameter int N       = 2,
   parameter int TIMEOUT = 255
) (
   input  logic                 clk_in,
   input  logic                 reset_in,
   input  logic [N-1:0][31:0]   bus_in_adr,
   input  logic [N-1:0][31:0]   bus_in_dat_w,
   input  logic [N-1:0][3:0]    bus_in_sel,
   input  logic [N-1:0]         bus_in_we,
   input  logic [N-1:0]         bus_in_cyc,
   input  logic [N-1:0]         bus_in_stb,
   output logic [N-1:0][31:0]   bus_in_dat_r,
   output logic [N-1:0]         bus_in_ack,
   output logic [31:0]          bus_out_adr,
   output logic [31:0]          bus_out_dat_w,
   output logic [3:0]           bus_out_sel,
   output logic                 bus_out_we,
   output logic                 bus_out_cyc,
   output logic                 bus_out_stb,
   input  logic [31:0]          bus_out_dat_r,
   input  logic                 bus_out_ack,
   output logic [N-1:0]         grant_out,
   output logic                 timeout_out
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;

   generate
      if (N < 2 || N > 8) begin : g_bad_n
         $error("wb_arbiter: N must be in 2..8");
      end
      if (TIMEOUT < 1) begin : g_bad_tmo
         $error("wb_arbiter: TIMEOUT must be >= 1");
      end
   endgenerate

   typedef enum logic {
      IDLE,
      BUSY
   } state_t;

   state_t          state;
   logic [IW-1:0]   gidx;
   logic [IW-1:0]   last;
   logic [IW-1:0]   win;
   logic            any_req;
   logic            act;
   logic            tmo_hit;
   int              idx;

   logic [31:0]     g_adr;
   logic [31:0]     g_dat_w;
   logic [3:0]      g_sel;
   logic            g_we;
   logic            g_cyc;
   logic            g_stb;

   // A reset held low blanks the shared bus and all acks at once.
   assign act = (state == BUSY) && reset_in;

   // Round-robin search starting just after the last winner.
   always_comb begin
      win     = '0;
      any_req = 1'b0;
      idx     = 0;
      for (int k = 1; k <= N; k++) begin
         idx = (int'(last) + k) % N;
         if (!any_req && bus_in_cyc[idx]) begin
            any_req = 1'b1;
            win     = IW'(idx);
         end
      end
   end

   // Select the granted master's request signals.
   always_comb begin
      g_adr   = '0;
      g_dat_w = '0;
      g_sel   = '0;
      g_we    = 1'b0;
      g_cyc   = 1'b0;
      g_stb   = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (gidx == IW'(i)) begin
            g_adr   = bus_in_adr[i];
            g_dat_w = bus_in_dat_w[i];
            g_sel   = bus_in_sel[i];
            g_we    = bus_in_we[i];
            g_cyc   = bus_in_cyc[i];
            g_stb   = bus_in_stb[i];
         end
      end
   end

`ifdef WB_ARBITER_TIMEOUT_EN
   logic [31:0] cnt;
   logic        tmo_q;

   assign tmo_hit     = act && (cnt == 32'(TIMEOUT));
   assign timeout_out = tmo_q;

   // Stall watchdog; cleared outside BUSY, on ack and after firing.
   always_ff @(posedge clk_in) begin
      if (!reset_in) begin
         cnt   <= '0;
         tmo_q <= 1'b0;
      end else begin
         if (state != BUSY || bus_out_ack || tmo_hit) begin
            cnt <= '0;
         end else if (bus_out_stb) begin
            cnt <= cnt + 32'd1;
         end
         if (tmo_hit) begin
            tmo_q <= 1'b1;
         end
      end
   end
`else
   assign tmo_hit     = 1'b0;
   assign timeout_out = 1'b0;
`endif

   // Mirror the granted master onto the shared bus and route responses back.
   always_comb begin
      bus_out_adr   = '0;
      bus_out_dat_w = '0;
      bus_out_sel   = '0;
      bus_out_we    = 1'b0;
      bus_out_cyc   = 1'b0;
      bus_out_stb   = 1'b0;
      bus_in_ack    = '0;
      bus_in_dat_r  = '0;
      if (act) begin
         bus_out_adr   = g_adr;
         bus_out_dat_w = g_dat_w;
         bus_out_sel   = g_sel;
         bus_out_we    = g_we;
         bus_out_cyc   = g_cyc;
         bus_out_stb   = g_stb & ~tmo_hit;
         for (int i = 0; i < N; i++) begin
            if (gidx == IW'(i)) begin
               bus_in_ack[i] = bus_out_ack | tmo_hit;
               if (tmo_hit) begin
                  bus_in_dat_r[i] = 32'hBAD0_0000 | 32'(i);
               end else begin
                  bus_in_dat_r[i] = bus_out_dat_r;
               end
            end
         end
      end
   end

   // Grant FSM: pick a winner in IDLE, hold it until its cyc drops.
   always_ff @(posedge clk_in) begin
      if (!reset_in) begin
         state     <= IDLE;
         grant_out <= '0;
         last      <= IW'(N - 1);
         gidx      <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (any_req) begin
                  state     <= BUSY;
                  grant_out <= N'(1) << win;
                  last      <= win;
                  gidx      <= win;
               end
            end
            BUSY: begin
               if (!g_cyc) begin
                  state     <= IDLE;
                  grant_out <= '0;
               end
            end
            default: begin
               state     <= IDLE;
               grant_out <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed self-checking bench for wb_arbiter, N=3.
// Covers reset, grant, round-robin, block hold, drop, watchdog.
module tb_wb_arbiter;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [2:0][31:0]  m_adr;
   logic [2:0][31:0]  m_dat_w;
   logic [2:0][3:0]   m_sel;
   logic [2:0]        m_we;
   logic [2:0]        m_cyc;
   logic [2:0]        m_stb;
   logic [2:0][31:0]  m_dat_r;
   logic [2:0]        m_ack;
   logic [31:0]       s_adr;
   logic [31:0]       s_dat_w;
   logic [3:0]        s_sel;
   logic              s_we;
   logic              s_cyc;
   logic              s_stb;
   logic [31:0]       s_dat_r;
   logic              s_ack;
   logic              slave_en;
   logic [2:0]        grant;
   logic              tmo;

   int checks = 0;
   int fails  = 0;

   assign s_ack = slave_en & s_cyc & s_stb;

   always #5 clk = ~clk;

   wb_arbiter #(.N(3), .TIMEOUT(4)) dut (
      .clk_in        (clk),
      .reset_in      (rst_n),
      .bus_in_adr    (m_adr),
      .bus_in_dat_w  (m_dat_w),
      .bus_in_sel    (m_sel),
      .bus_in_we     (m_we),
      .bus_in_cyc    (m_cyc),
      .bus_in_stb    (m_stb),
      .bus_in_dat_r  (m_dat_r),
      .bus_in_ack    (m_ack),
      .bus_out_adr   (s_adr),
      .bus_out_dat_w (s_dat_w),
      .bus_out_sel   (s_sel),
      .bus_out_we    (s_we),
      .bus_out_cyc   (s_cyc),
      .bus_out_stb   (s_stb),
      .bus_out_dat_r (s_dat_r),
      .bus_out_ack   (s_ack),
      .grant_out     (grant),
      .timeout_out   (tmo)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      m_cyc    = 3'b111;
      m_stb    = 3'b111;
      m_adr[0] = 32'h1111_0000;
      slave_en = 1'b1;
      rst_n    = 1'b0;
      for (int c = 0; c < 2; c++) begin
         tick();
         checks++;
         if (grant !== 3'b000) begin
            fails++;
            $display("FAIL reset_grant: got %b want 000", grant);
         end
         checks++;
         if (s_cyc !== 1'b0 || s_adr !== 32'h0) begin
            fails++;
            $display("FAIL reset_bus: cyc %b adr %h want 0 0", s_cyc, s_adr);
         end
         checks++;
         if (m_ack !== 3'b000 || tmo !== 1'b0) begin
            fails++;
            $display("FAIL reset_ack: ack %b tmo %b want 000 0", m_ack, tmo);
         end
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (grant !== 3'b001) begin
         fails++;
         $display("FAIL reset_release: got %b want 001", grant);
      end
      m_cyc = 3'b000;
      m_stb = 3'b000;
      tick();
      tick();
   endtask

   task automatic test_single();
      do_reset();
      m_cyc[1]   = 1'b1;
      m_stb[1]   = 1'b1;
      m_we[1]    = 1'b1;
      m_sel[1]   = 4'hF;
      m_adr[1]   = 32'h0000_3000;
      m_dat_w[1] = 32'hCAFE_F00D;
      slave_en   = 1'b1;
      s_dat_r    = 32'h1234_5678;
      #1;
      checks++;
      if (s_cyc !== 1'b0 || grant !== 3'b000) begin
         fails++;
         $display("FAIL single_pre: cyc %b grant %b want 0 000", s_cyc, grant);
      end
      tick();
      checks++;
      if (grant !== 3'b010) begin
         fails++;
         $display("FAIL single_grant: got %b want 010", grant);
      end
      checks++;
      if (s_cyc !== 1'b1 || s_stb !== 1'b1 || s_we !== 1'b1 ||
          s_sel !== 4'hF) begin
         fails++;
         $display("FAIL single_ctl: cyc %b stb %b we %b sel %h", s_cyc, s_stb, s_we, s_sel);
      end
      checks++;
      if (s_adr !== 32'h0000_3000 || s_dat_w !== 32'hCAFE_F00D) begin
         fails++;
         $display("FAIL single_data: adr %h dat %h want 3000 cafef00d", s_adr, s_dat_w);
      end
      checks++;
      if (m_ack !== 3'b010) begin
         fails++;
         $display("FAIL single_ack: got %b want 010", m_ack);
      end
      checks++;
      if (m_dat_r[1] !== 32'h1234_5678 || m_dat_r[0] !== 32'h0) begin
         fails++;
         $display("FAIL single_datr: m1 %h m0 %h want 12345678 0", m_dat_r[1], m_dat_r[0]);
      end
      m_cyc[1] = 1'b0;
      m_stb[1] = 1'b0;
      tick();
      checks++;
      if (grant !== 3'b000 || s_cyc !== 1'b0 || m_ack !== 3'b000) begin
         fails++;
         $display("FAIL single_end: grant %b cyc %b ack %b", grant, s_cyc, m_ack);
      end
   endtask

   task automatic test_contention();
      logic [2:0] exp [7];
      exp = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
      m_cyc    = 3'b111;
      m_stb    = 3'b111;
      slave_en = 1'b1;
      do_reset();
      for (int j = 0; j < 7; j++) begin
         tick();
         checks++;
         if (grant !== exp[j]) begin
            fails++;
            $display("FAIL contention_%0d: got %b want %b", j, grant, exp[j]);
         end
         m_cyc = ~m_ack;
         m_stb = ~m_ack;
      end
      m_cyc = 3'b000;
      m_stb = 3'b000;
      tick();
      tick();
   endtask

   task automatic test_block();
      do_reset();
      m_cyc    = 3'b011;
      m_stb    = 3'b011;
      slave_en = 1'b1;
      tick();
      for (int b = 0; b < 4; b++) begin
         if (b > 0) tick();
         checks++;
         if (grant !== 3'b001 || m_ack !== 3'b001) begin
            fails++;
            $display("FAIL block_beat%0d: grant %b ack %b want 001 001", b, grant, m_ack);
         end
      end
      m_cyc[0] = 1'b0;
      m_stb[0] = 1'b0;
      tick();
      checks++;
      if (grant !== 3'b000 || m_ack !== 3'b000) begin
         fails++;
         $display("FAIL block_gap: grant %b ack %b want 000 000", grant, m_ack);
      end
      tick();
      checks++;
      if (grant !== 3'b010) begin
         fails++;
         $display("FAIL block_next: got %b want 010", grant);
      end
      m_cyc = 3'b000;
      m_stb = 3'b000;
      tick();
      tick();
   endtask

   task automatic test_drop();
      do_reset();
      slave_en = 1'b1;
      m_cyc[2] = 1'b1;
      m_stb[2] = 1'b1;
      tick();
      checks++;
      if (grant !== 3'b100) begin
         fails++;
         $display("FAIL drop_grant: got %b want 100", grant);
      end
      m_cyc = 3'b000;
      m_stb = 3'b000;
      #1;
      checks++;
      if (s_cyc !== 1'b0 || m_ack !== 3'b000) begin
         fails++;
         $display("FAIL drop_bus: cyc %b ack %b want 0 000", s_cyc, m_ack);
      end
      tick();
      checks++;
      if (grant !== 3'b000) begin
         fails++;
         $display("FAIL drop_idle: got %b want 000", grant);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      slave_en = 1'b0;
      m_cyc[1] = 1'b1;
      m_stb[1] = 1'b1;
      tick();
`ifdef WB_ARBITER_TIMEOUT_EN
      for (int c = 1; c <= 4; c++) begin
         checks++;
         if (m_ack !== 3'b000 || s_stb !== 1'b1 || tmo !== 1'b0) begin
            fails++;
            $display("FAIL tmo_stall%0d: ack %b stb %b tmo %b", c, m_ack, s_stb, tmo);
         end
         tick();
      end
      checks++;
      if (m_ack !== 3'b010 || m_dat_r[1] !== 32'hBAD0_0001) begin
         fails++;
         $display("FAIL tmo_fire: ack %b dat %h want 010 bad00001", m_ack, m_dat_r[1]);
      end
      checks++;
      if (s_stb !== 1'b0) begin
         fails++;
         $display("FAIL tmo_stb: got %b want 0", s_stb);
      end
      tick();
      checks++;
      if (tmo !== 1'b1 || m_ack !== 3'b000 || s_stb !== 1'b1) begin
         fails++;
         $display("FAIL tmo_after: tmo %b ack %b stb %b", tmo, m_ack, s_stb);
      end
      m_cyc = 3'b000;
      m_stb = 3'b000;
      tick();
      tick();
      checks++;
      if (tmo !== 1'b1 || grant !== 3'b000) begin
         fails++;
         $display("FAIL tmo_sticky: tmo %b grant %b want 1 000", tmo, grant);
      end
`else
      for (int c = 1; c <= 6; c++) begin
         checks++;
         if (m_ack !== 3'b000 || tmo !== 1'b0 || grant !== 3'b010) begin
            fails++;
            $display("FAIL wait%0d: ack %b tmo %b grant %b", c, m_ack, tmo, grant);
         end
         tick();
      end
      m_cyc = 3'b000;
      m_stb = 3'b000;
      tick();
`endif
   endtask

   task automatic test_reset_mid();
      do_reset();
      slave_en = 1'b0;
      m_cyc[0] = 1'b1;
      m_stb[0] = 1'b1;
      tick();
      checks++;
      if (grant !== 3'b001 || s_stb !== 1'b1) begin
         fails++;
         $display("FAIL mid_busy: grant %b stb %b want 001 1", grant, s_stb);
      end
      rst_n    = 1'b0;
      slave_en = 1'b1;
      #1;
      checks++;
      if (m_ack !== 3'b000) begin
         fails++;
         $display("FAIL mid_noack: got %b want 000", m_ack);
      end
      tick();
      checks++;
      if (grant !== 3'b000 || s_cyc !== 1'b0 || m_ack !== 3'b000) begin
         fails++;
         $display("FAIL mid_reset: grant %b cyc %b ack %b", grant, s_cyc, m_ack);
      end
      rst_n = 1'b1;
      m_cyc = 3'b000;
      m_stb = 3'b000;
      tick();
   endtask

   initial begin
      rst_n    = 1'b0;
      m_adr    = '0;
      m_dat_w  = '0;
      m_sel    = '0;
      m_we     = '0;
      m_cyc    = '0;
      m_stb    = '0;
      s_dat_r  = '0;
      slave_en = 1'b0;
      test_reset();
      test_single();
      test_contention();
      test_block();
      test_drop();
      test_timeout();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
